// File: rtl/pwm_core_if.sv
// pwm_core_if: CSR-side duty/divisor inputs and PWM pin output of pwm_core
interface pwm_core_if;
  logic [31:0] duty;
  logic [31:0] dvsr;
  logic        pwm_out;
  modport master(output duty, dvsr, input pwm_out);
  modport slave(input duty, dvsr, output pwm_out);
endinterface

// File: rtl/pwm_core.sv
// pwm_core: free-running prescaled PWM; define PWM_DUTY_SHADOW_EN to latch duty only at period wrap
module pwm_core #(
  parameter int R = 10
) (
  input logic       clock,
  input logic       resetn,
  pwm_core_if.slave bus
);
  logic [31:0] q_reg;
  logic [R-1:0] d_reg;
  logic [R:0] duty_eff;
  logic tick;
  logic pwm_next;
  logic unused_duty_hi;
  assign unused_duty_hi = ^bus.duty[31:R+1];
  // >= rather than == so a lowered divisor ticks at once instead of wrapping q_reg
  assign tick = q_reg >= bus.dvsr;
`ifdef PWM_DUTY_SHADOW_EN
  logic [R:0] shadow;
  always_ff @(posedge clock)
    if (!resetn) shadow <= '0;
    else if (tick && &d_reg) shadow <= bus.duty[R:0];
  assign duty_eff = shadow;
`else
  assign duty_eff = bus.duty[R:0];
`endif
  assign pwm_next = {1'b0, d_reg} < duty_eff;
  always_ff @(posedge clock)
    if (!resetn) begin
      q_reg       <= '0;
      d_reg       <= '0;
      bus.pwm_out <= 1'b0;
    end else begin
      q_reg       <= tick ? '0 : q_reg + 32'd1;
      d_reg       <= tick ? d_reg + 1'b1 : d_reg;
      bus.pwm_out <= pwm_next;
    end
endmodule

// File: tb/tb_pwm_core.sv
// tb_pwm_core: directed scoreboard bench; expected pwm_out per cycle is queued, a monitor pops and compares
module tb_pwm_core;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  pwm_core_if pwm();
  pwm_core #(.R(10)) dut (.clock(clock), .resetn(resetn), .bus(pwm));
  always #5 clock = ~clock;
  bit    exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    idx = 0;
  string tag = "init";
  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      bit e;
      e = exp_q.pop_front();
      n_checks++;
      if (pwm.pwm_out !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: pwm_out=%b expected %b", tag, idx, pwm.pwm_out, e);
      end
      idx++;
    end
  end
  task automatic push(input bit lvl, input int len);
    for (int i = 0; i < len; i++) exp_q.push_back(lvl);
  endtask
  task automatic drain();
    for (int i = 0; i < 20000 && exp_q.size() > 0; i++) @(negedge clock);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s drain timeout: %0d entries left, expected 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic start(input string name, input logic [31:0] d, input logic [31:0] v);
    drain();
    @(negedge clock);
    tag = name;
    idx = 0;
    resetn = 1'b0;
    pwm.duty = d;
    pwm.dvsr = v;
    push(1'b0, 1);
    @(negedge clock);
    resetn = 1'b1;
  endtask
  initial begin
    pwm.duty = '0;
    pwm.dvsr = '0;
    repeat (2) @(negedge clock);
    start("zero", 32'd0, 32'd0);
    push(1'b0, 2100);
`ifdef PWM_DUTY_SHADOW_EN
    start("shadow", 32'd512, 32'd0);
    push(1'b0, 1024); push(1'b1, 512); push(1'b0, 512); push(1'b1, 100); push(1'b0, 924);
    repeat (1074) @(negedge clock);
    pwm.duty = 32'd100;
`else
    start("half", 32'd512, 32'd0);
    push(1'b1, 512); push(1'b0, 512); push(1'b1, 512); push(1'b0, 512);
    start("dvsr3", 32'd256, 32'd3);
    push(1'b1, 1024); push(1'b0, 3072); push(1'b1, 1024);
    start("full", 32'd1024, 32'd0);
    push(1'b1, 2100);
    start("over", 32'd2047, 32'd0);
    push(1'b1, 2100);
    start("hibits", 32'h0000_0A00, 32'd0);
    push(1'b1, 512); push(1'b0, 512); push(1'b1, 512);
    start("dvsr_drop", 32'd1, 32'd100);
    push(1'b1, 51); push(1'b0, 6138); push(1'b1, 6); push(1'b0, 10);
    repeat (50) @(negedge clock);
    pwm.dvsr = 32'd5;
    start("rst_mid", 32'd512, 32'd0);
    push(1'b1, 100); push(1'b0, 1); push(1'b1, 512); push(1'b0, 512);
    repeat (100) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
`endif
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_core.md
Name: pwm_core

Overview:
- Free-running pulse-width modulator with a programmable clock prescaler and an (R+1)-bit duty value.
- Sits behind the Avalon PWM CSR wrapper. The wrapper drives `duty` from CSR0 and `dvsr` from CSR1; `pwm_out` goes straight to the export pin.
- PWM period is 2^R duty steps. Each step lasts dvsr+1 clock cycles.

Parameters:
- R, default 10: resolution in bits. The duty step counter is R bits wide; the used duty field is R+1 bits.

Ports:
- clock, input, 1: system clock; all logic is on the rising edge.
- resetn, input, 1: synchronous, active-low reset.
- duty, input, 32: duty cycle. Only duty[R:0] is used; duty[31:R+1] is ignored.
- dvsr, input, 32: prescaler divisor. One duty step lasts dvsr+1 clocks.
- pwm_out, output, 1: registered PWM output.

Behaviour:
- Interface: one clock (`clock`). Reset `resetn` is synchronous and active-low. No asynchronous reset paths.
- Reset (resetn=0 at a rising edge):
  - prescaler q_reg = 0
  - step counter d_reg = 0
  - pwm_out = 0
  - shadow duty = 0, when the optional feature is present
- Prescaler:
  - q_reg is 32 bits.
  - When q_reg >= dvsr: tick=1 and q_reg <= 0 on the next edge.
  - Otherwise: tick=0 and q_reg <= q_reg+1.
  - The >= compare means lowering dvsr below the current q_reg produces a tick on the next cycle, with no 2^32 wrap.
  - dvsr=0 gives tick every cycle.
- Step counter:
  - d_reg is R bits and increments by 1 on each tick.
  - It wraps from 2^R-1 to 0; the wrap marks the start of a new PWM period.
- Comparator:
  - pwm_next = ({1'b0, d_reg} < duty_eff[R:0]), an unsigned (R+1)-bit compare.
  - pwm_out <= pwm_next each cycle, giving one cycle of latency after d_reg.
- Duty boundaries:
  - duty_eff=0: pwm_out stays at 0 permanently.
  - duty_eff >= 2^R: pwm_out is 1 every cycle after the first post-reset cycle (100% duty).
  - 0 < duty_eff < 2^R: pwm_out is high for duty_eff*(dvsr+1) clocks per period of 2^R*(dvsr+1) clocks. Each period begins with its high phase.
- Live updates: without the optional feature, changes to `duty` or `dvsr` take effect on the next clock edge.
- Reset mid-operation: all state returns to its reset value on the next edge. After resetn is released, counting restarts from q_reg=0, d_reg=0.
- No overflow flags and no other outputs.

Optional Feature:
- Macro: PWM_DUTY_SHADOW_EN.
- When defined:
  - duty[R:0] is captured into an (R+1)-bit shadow register only on a tick where d_reg = 2^R-1, i.e. at the period wrap.
  - duty_eff = shadow. Mid-period duty writes cannot produce glitch pulses.
  - After reset the shadow is 0, so the output stays low until the first period wrap.
- When undefined: duty_eff = duty[R:0], taken combinationally. No shadow register exists.

Test Plan:
- R=10, dvsr=0, duty=512, reset released → pwm_out high for 512 clocks, then low for 512, repeating with period 1024. First rising edge of pwm_out is one cycle after reset release.
- R=10, dvsr=3, duty=256 → high for 1024 clocks, low for 3072, period 4096. tick asserts every 4th cycle.
- duty=0 → pwm_out is never 1. duty=1024 (and duty=2047) → pwm_out is constantly 1 after the first cycle.
- duty=0x00000A00 (bits above R set, duty[10:0]=0x200) → behaves identically to duty=512.
- dvsr changed from 100 to 5 while q_reg=50 → tick on the next cycle, q_reg returns to 0, then ticks every 6 clocks.
- resetn pulsed low for one cycle mid-high-phase → pwm_out=0, q_reg=0, d_reg=0 on that edge, then normal restart.
- With PWM_DUTY_SHADOW_EN, duty changed 512→100 at d_reg=50 → the current period keeps a 512-step high phase; the next period is high for 100 steps.
